// File: rtl/fight_arbiter.sv
// Two-player combat core: tick-paced movement with collision, edge-triggered attacks and a best-of-N round FSM.
// Hits resolve in the clk after the attack edge; positions move one step per tick. There is no handshake and inputs are sampled every clk.
module fight_arbiter #(
  parameter int HEALTH_W      = 4,
  parameter int MAX_HEALTH    = 15,
  parameter int DAMAGE        = 1,
  parameter int CHIP_DAMAGE   = 0,
  parameter int CHAR_W        = 80,
  parameter int REACH         = 8,
  parameter int X_MIN         = 143,
  parameter int X_MAX         = 784,
  parameter int GROUND_Y      = 300,
  parameter int P1_START_X    = 200,
  parameter int P2_START_X    = 600,
  parameter int WALK_DIV      = 800000,
  parameter int HIT_COOLDOWN  = 25000000,
  parameter int PAUSE_CYCLES  = 100000000,
  parameter int ROUNDS_TO_WIN = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                p1_left,
  input  logic                p1_right,
  input  logic                p1_attack_req,
  input  logic                p1_shielding,
  input  logic                p1_facing,
  input  logic                p1_jump_active,
  input  logic                p1_jump_desc,
  input  logic                p2_left,
  input  logic                p2_right,
  input  logic                p2_attack_req,
  input  logic                p2_shielding,
  input  logic                p2_facing,
  input  logic                p2_jump_active,
  input  logic                p2_jump_desc,
  output logic [9:0]          p1_x,
  output logic [9:0]          p1_y,
  output logic [9:0]          p2_x,
  output logic [9:0]          p2_y,
  output logic [HEALTH_W-1:0] p1_health,
  output logic [HEALTH_W-1:0] p2_health,
  output logic [1:0]          p1_rounds,
  output logic [1:0]          p2_rounds,
  output logic                p1_hit,
  output logic                p2_hit,
  output logic [1:0]          round_state,
  output logic [1:0]          finish
);
  localparam int TW = (WALK_DIV > 1) ? $clog2(WALK_DIV) : 1;
  localparam int CW = $clog2(HIT_COOLDOWN + 1);
  localparam int PW = (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES) : 1;

  localparam logic [TW-1:0]       TICK_LAST  = TW'(WALK_DIV - 1);
  localparam logic [PW-1:0]       PAUSE_LAST = PW'(PAUSE_CYCLES - 1);
  localparam logic [CW-1:0]       COOL_C     = CW'(HIT_COOLDOWN);
  localparam logic [9:0]          X_MIN_C    = 10'(X_MIN);
  localparam logic [9:0]          X_MAX_C    = 10'(X_MAX);
  localparam logic [9:0]          CHAR_C     = 10'(CHAR_W);
  localparam logic [9:0]          RANGE_C    = 10'(CHAR_W + REACH);
  localparam logic [9:0]          GROUND_C   = 10'(GROUND_Y);
  localparam logic [9:0]          P1_START_C = 10'(P1_START_X);
  localparam logic [9:0]          P2_START_C = 10'(P2_START_X);
  localparam logic [HEALTH_W-1:0] MAX_H      = HEALTH_W'(MAX_HEALTH);
  localparam logic [HEALTH_W-1:0] DMG_C      = HEALTH_W'(DAMAGE);
  localparam logic [HEALTH_W-1:0] CHIP_C     = HEALTH_W'(CHIP_DAMAGE);
  localparam logic [1:0]          RTW        = 2'(ROUNDS_TO_WIN);

  typedef enum logic [1:0] {
    S_FIGHT      = 2'b00,
    S_ROUND_OVER = 2'b01,
    S_MATCH_OVER = 2'b10
  } state_t;

  function automatic logic [9:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  function automatic logic [9:0] move_x(input logic [9:0] x, input logic l, input logic r,
                                        input logic [9:0] other_x, input logic same_y);
    logic [9:0] c;
    c = x;
    if (l && !r && x > X_MIN_C)                c = x - 10'd1;
    else if (r && !l && (x + CHAR_C) < X_MAX_C) c = x + 10'd1;
    if (same_y && abs_diff(c, other_x) < CHAR_C) c = x;
    return c;
  endfunction

  function automatic logic [9:0] move_y(input logic [9:0] y, input logic act, input logic desc);
    if (!act)                return GROUND_C;
    else if (!desc)          return (y != 10'd0) ? (y - 10'd1) : y;
    else if (y >= GROUND_C - 10'd1) return GROUND_C;
    else                     return y + 10'd1;
  endfunction

  state_t              state_q, state_d;
  logic [TW-1:0]       tick_q, tick_d;
  logic [PW-1:0]       pause_q, pause_d;
  logic [9:0]          p1_x_q, p1_x_d, p2_x_q, p2_x_d, p1_y_q, p1_y_d, p2_y_q, p2_y_d;
  logic [HEALTH_W-1:0] p1_hp_q, p1_hp_d, p2_hp_q, p2_hp_d;
  logic [CW-1:0]       p1_cd_q, p1_cd_d, p2_cd_q, p2_cd_d;
  logic [1:0]          p1_rnd_q, p1_rnd_d, p2_rnd_q, p2_rnd_d, finish_q, finish_d;
  logic                p1_hit_q, p1_hit_d, p2_hit_q, p2_hit_d;
  logic                p1_atk_q, p2_atk_q;

  logic                tick, in_range, p1_lands, p2_lands;
  logic [HEALTH_W-1:0] dmg_to_p1, dmg_to_p2;

  assign tick      = (tick_q == TICK_LAST);
  assign in_range  = abs_diff(p1_x_q, p2_x_q) <= RANGE_C;
  assign dmg_to_p1 = p1_shielding ? CHIP_C : DMG_C;
  assign dmg_to_p2 = p2_shielding ? CHIP_C : DMG_C;

  // Attacker must face the defender; equal x faces nobody.
  assign p1_lands = p1_attack_req && !p1_atk_q && in_range && (p2_cd_q == '0) && (p2_hp_q != '0) &&
                    ((p1_x_q < p2_x_q && !p1_facing) || (p1_x_q > p2_x_q && p1_facing));
  assign p2_lands = p2_attack_req && !p2_atk_q && in_range && (p1_cd_q == '0) && (p1_hp_q != '0) &&
                    ((p2_x_q < p1_x_q && !p2_facing) || (p2_x_q > p1_x_q && p2_facing));

  always_comb begin
    state_d  = state_q;
    tick_d   = tick ? '0 : tick_q + 1'b1;
    pause_d  = pause_q;
    p1_x_d   = p1_x_q;
    p2_x_d   = p2_x_q;
    p1_y_d   = p1_y_q;
    p2_y_d   = p2_y_q;
    p1_hp_d  = p1_hp_q;
    p2_hp_d  = p2_hp_q;
    p1_cd_d  = (p1_cd_q != '0) ? p1_cd_q - 1'b1 : '0;
    p2_cd_d  = (p2_cd_q != '0) ? p2_cd_q - 1'b1 : '0;
    p1_rnd_d = p1_rnd_q;
    p2_rnd_d = p2_rnd_q;
    finish_d = finish_q;
    p1_hit_d = 1'b0;
    p2_hit_d = 1'b0;

    case (state_q)
      S_FIGHT: begin
        if (tick) begin
          // P2 is checked against P1's new x so a simultaneous approach cannot overlap.
          p1_x_d = move_x(p1_x_q, p1_left, p1_right, p2_x_q, p1_y_q == p2_y_q);
          p2_x_d = move_x(p2_x_q, p2_left, p2_right, p1_x_d, p1_y_q == p2_y_q);
          p1_y_d = move_y(p1_y_q, p1_jump_active, p1_jump_desc);
          p2_y_d = move_y(p2_y_q, p2_jump_active, p2_jump_desc);
        end
        if (p1_lands) begin
          p2_hp_d = (p2_hp_q > dmg_to_p2) ? p2_hp_q - dmg_to_p2 : '0;
          if (dmg_to_p2 != '0) begin
            p2_cd_d  = COOL_C;
            p2_hit_d = 1'b1;
          end
        end
        if (p2_lands) begin
          p1_hp_d = (p1_hp_q > dmg_to_p1) ? p1_hp_q - dmg_to_p1 : '0;
          if (dmg_to_p1 != '0) begin
            p1_cd_d  = COOL_C;
            p1_hit_d = 1'b1;
          end
        end
        if (p1_hp_q == '0 || p2_hp_q == '0) begin
          state_d = S_ROUND_OVER;
          pause_d = '0;
          if (p2_hp_q == '0 && p1_hp_q != '0 && p1_rnd_q != RTW) p1_rnd_d = p1_rnd_q + 2'd1;
          if (p1_hp_q == '0 && p2_hp_q != '0 && p2_rnd_q != RTW) p2_rnd_d = p2_rnd_q + 2'd1;
        end
      end
      S_ROUND_OVER: begin
        if (pause_q != PAUSE_LAST) begin
          pause_d = pause_q + 1'b1;
        end else if (p1_rnd_q == RTW || p2_rnd_q == RTW) begin
          state_d  = S_MATCH_OVER;
          finish_d = (p1_rnd_q == RTW) ? 2'b01 : 2'b11;
        end else begin
          state_d = S_FIGHT;
          p1_x_d  = P1_START_C;
          p2_x_d  = P2_START_C;
          p1_y_d  = GROUND_C;
          p2_y_d  = GROUND_C;
          p1_hp_d = MAX_H;
          p2_hp_d = MAX_H;
          p1_cd_d = '0;
          p2_cd_d = '0;
        end
      end
      default: state_d = S_MATCH_OVER;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_FIGHT;
      tick_q   <= '0;
      pause_q  <= '0;
      p1_x_q   <= P1_START_C;
      p2_x_q   <= P2_START_C;
      p1_y_q   <= GROUND_C;
      p2_y_q   <= GROUND_C;
      p1_hp_q  <= MAX_H;
      p2_hp_q  <= MAX_H;
      p1_cd_q  <= '0;
      p2_cd_q  <= '0;
      p1_rnd_q <= '0;
      p2_rnd_q <= '0;
      finish_q <= '0;
      p1_hit_q <= 1'b0;
      p2_hit_q <= 1'b0;
      p1_atk_q <= 1'b0;
      p2_atk_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      pause_q  <= pause_d;
      p1_x_q   <= p1_x_d;
      p2_x_q   <= p2_x_d;
      p1_y_q   <= p1_y_d;
      p2_y_q   <= p2_y_d;
      p1_hp_q  <= p1_hp_d;
      p2_hp_q  <= p2_hp_d;
      p1_cd_q  <= p1_cd_d;
      p2_cd_q  <= p2_cd_d;
      p1_rnd_q <= p1_rnd_d;
      p2_rnd_q <= p2_rnd_d;
      finish_q <= finish_d;
      p1_hit_q <= p1_hit_d;
      p2_hit_q <= p2_hit_d;
      p1_atk_q <= p1_attack_req;
      p2_atk_q <= p2_attack_req;
    end
  end

  assign p1_x        = p1_x_q;
  assign p2_x        = p2_x_q;
  assign p1_y        = p1_y_q;
  assign p2_y        = p2_y_q;
  assign p1_health   = p1_hp_q;
  assign p2_health   = p2_hp_q;
  assign p1_rounds   = p1_rnd_q;
  assign p2_rounds   = p2_rnd_q;
  assign p1_hit      = p1_hit_q;
  assign p2_hit      = p2_hit_q;
  assign round_state = state_q;
  assign finish      = finish_q;
endmodule

// File: tb/tb_fight_arbiter.sv
// Bench for fight_arbiter: directed stimulus, expected hit/round events queued and checked by an independent monitor.
module tb_fight_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b0;
  logic p1_left = 0, p1_right = 0, p1_attack_req = 0, p1_shielding = 0, p1_facing = 0;
  logic p1_jump_active = 0, p1_jump_desc = 0;
  logic p2_left = 0, p2_right = 0, p2_attack_req = 0, p2_shielding = 0, p2_facing = 0;
  logic p2_jump_active = 0, p2_jump_desc = 0;
  logic [9:0] p1_x, p1_y, p2_x, p2_y;
  logic [3:0] p1_health, p2_health;
  logic [1:0] p1_rounds, p2_rounds, round_state, finish;
  logic       p1_hit, p2_hit;

  fight_arbiter #(.WALK_DIV(4), .HIT_COOLDOWN(10), .PAUSE_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .p1_left(p1_left), .p1_right(p1_right), .p1_attack_req(p1_attack_req),
    .p1_shielding(p1_shielding), .p1_facing(p1_facing),
    .p1_jump_active(p1_jump_active), .p1_jump_desc(p1_jump_desc),
    .p2_left(p2_left), .p2_right(p2_right), .p2_attack_req(p2_attack_req),
    .p2_shielding(p2_shielding), .p2_facing(p2_facing),
    .p2_jump_active(p2_jump_active), .p2_jump_desc(p2_jump_desc),
    .p1_x(p1_x), .p1_y(p1_y), .p2_x(p2_x), .p2_y(p2_y),
    .p1_health(p1_health), .p2_health(p2_health),
    .p1_rounds(p1_rounds), .p2_rounds(p2_rounds),
    .p1_hit(p1_hit), .p2_hit(p2_hit),
    .round_state(round_state), .finish(finish)
  );

  typedef struct packed {
    logic       h1;
    logic       h2;
    logic [3:0] hp1;
    logic [3:0] hp2;
    logic [1:0] r1;
    logic [1:0] r2;
    logic [1:0] rs;
    logic [1:0] fin;
  } snap_t;

  snap_t exp_q[$];
  int    checks   = 0;
  int    failures = 0;
  logic  mon_en   = 1'b0;
  logic [1:0] prev_rs = 2'b00;

  function automatic snap_t mk(input logic h1, input logic h2, input int hp1, input int hp2,
                               input int r1, input int r2, input int rs, input int fin);
    snap_t s;
    s.h1 = h1; s.h2 = h2; s.hp1 = 4'(hp1); s.hp2 = 4'(hp2);
    s.r1 = 2'(r1); s.r2 = 2'(r2); s.rs = 2'(rs); s.fin = 2'(fin);
    return s;
  endfunction

  // Monitor: any hit pulse or round_state change is an output event.
  always @(negedge clk) begin
    snap_t cur, e;
    if (mon_en) begin
      cur = '{p1_hit, p2_hit, p1_health, p2_health, p1_rounds, p2_rounds, round_state, finish};
      if (p1_hit || p2_hit || round_state != prev_rs) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_event actual=%h required=none t=%0t", cur, $time);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin
            failures++;
            $display("FAIL event actual=%h required=%h t=%0t", cur, e, $time);
          end
        end
      end
      prev_rs = round_state;
    end
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Four clks always contain exactly one movement tick.
  task automatic step(input logic l1, input logic r1, input logic l2, input logic r2);
    p1_left = l1; p1_right = r1; p2_left = l2; p2_right = r2;
    clks(4);
    p1_left = 0; p1_right = 0; p2_left = 0; p2_right = 0;
  endtask

  task automatic attack(input logic a1, input logic a2);
    p1_attack_req = a1; p2_attack_req = a2;
    clks(1);
    p1_attack_req = 0; p2_attack_req = 0;
    clks(1);
  endtask

  task automatic pause_len();
    int n;
    n = 0;
    while (round_state == 2'b01 && n < 40) begin
      n++;
      clks(1);
    end
    chk("pause_len", n, 8);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    clks(2);
    reset = 1'b1;
    chk("rst_p1_x", p1_x, 200);       chk("rst_p2_x", p2_x, 600);
    chk("rst_p1_y", p1_y, 300);       chk("rst_p2_y", p2_y, 300);
    chk("rst_p1_hp", p1_health, 15);  chk("rst_p2_hp", p2_health, 15);
    chk("rst_p1_rnd", p1_rounds, 0);  chk("rst_p2_rnd", p2_rounds, 0);
    chk("rst_finish", finish, 0);     chk("rst_state", round_state, 0);
    chk("rst_hits", {p1_hit, p2_hit}, 0);
    mon_en = 1'b1;

    // Jump: rise one px, fall back, saturate at ground.
    p1_jump_active = 1; clks(4); chk("jump_up", p1_y, 299);
    p1_jump_desc = 1;   clks(4); chk("jump_down", p1_y, 300);
    clks(4);                     chk("jump_sat", p1_y, 300);
    p1_jump_active = 0; p1_jump_desc = 0;

    for (int i = 0; i < 220; i++) step(0, 1, (i < 99), 0);
    chk("walk_p1_x", p1_x, 420); chk("walk_p2_x", p2_x, 501);
    step(0, 1, 1, 0);
    chk("coll_p1_x", p1_x, 421); chk("coll_p2_x", p2_x, 501);
    step(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
    chk("pos_p1_x", p1_x, 420); chk("pos_p2_x", p2_x, 505);

    exp_q.push_back(mk(0, 1, 15, 14, 0, 0, 0, 0));
    attack(1, 0);
    attack(1, 0);
    chk("cooldown_hp", p2_health, 14);
    clks(12);
    p2_shielding = 1; attack(1, 0); chk("shield_hp", p2_health, 14); p2_shielding = 0;
    clks(2);
    p1_facing = 1; attack(1, 0); chk("facing_hp", p2_health, 14); p1_facing = 0;
    clks(2);

    for (int hp = 13; hp >= 1; hp--) begin
      exp_q.push_back(mk(0, 1, 15, hp, 0, 0, 0, 0));
      attack(1, 0);
      clks(10);
    end
    exp_q.push_back(mk(0, 1, 15, 0, 0, 0, 0, 0));
    exp_q.push_back(mk(0, 0, 15, 0, 1, 0, 1, 0));
    exp_q.push_back(mk(0, 0, 15, 15, 1, 0, 0, 0));
    attack(1, 0);
    pause_len();
    chk("r1_p1_x", p1_x, 200); chk("r1_p2_x", p2_x, 600);
    chk("r1_p1_rnd", p1_rounds, 1);

    for (int i = 0; i < 215; i++) step(0, (i < 100), 1, 0);
    chk("r2_p1_x", p1_x, 300); chk("r2_p2_x", p2_x, 385);
    for (int hp = 14; hp >= 1; hp--) begin
      exp_q.push_back(mk(0, 1, 15, hp, 1, 0, 0, 0));
      attack(1, 0);
      clks(10);
    end
    exp_q.push_back(mk(0, 1, 15, 0, 1, 0, 0, 0));
    exp_q.push_back(mk(0, 0, 15, 0, 2, 0, 1, 0));
    exp_q.push_back(mk(0, 0, 15, 0, 2, 0, 2, 1));
    attack(1, 0);
    pause_len();
    chk("match_state", round_state, 2); chk("match_finish", finish, 1);

    p2_facing = 1;
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0);
    attack(1, 1);
    clks(12);
    chk("frozen_p1_x", p1_x, 300);   chk("frozen_p2_x", p2_x, 385);
    chk("frozen_p1_hp", p1_health, 15); chk("frozen_state", round_state, 2);

    exp_q.push_back(mk(0, 0, 15, 15, 0, 0, 0, 0));
    reset = 1'b0; clks(2); reset = 1'b1;
    chk("rst2_p1_x", p1_x, 200); chk("rst2_finish", finish, 0);

    for (int i = 0; i < 215; i++) step(0, (i < 100), 1, 0);
    for (int hp = 14; hp >= 1; hp--) begin
      exp_q.push_back(mk(1, 1, hp, hp, 0, 0, 0, 0));
      attack(1, 1);
      clks(10);
    end
    exp_q.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0));
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0));
    exp_q.push_back(mk(0, 0, 15, 15, 0, 0, 0, 0));
    attack(1, 1);
    pause_len();
    chk("draw_p1_rnd", p1_rounds, 0); chk("draw_p2_rnd", p2_rounds, 0);
    chk("draw_p1_x", p1_x, 200);

    clks(5);
    chk("pending_events", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
